rvfi_order_sequencer: RTL and testbench

- Sits between a core's multi-channel RVFI retire port and single-channel consistency checkers (register, PC-chain, etc.).
- Collects retirements that can arrive on any of NRET channels and out of program order.
- Buffers them by rvfi_order in a small reorder window.
- Re-emits them strictly in order, at most one per cycle, on a single RVFI-style channel.
- Flags protocol violations: window overflow, duplicate order, and optionally a stalled head.

---
 rtl/rvfi_order_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_rvfi_order_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_order_sequencer.sv
// Reorders RVFI retirements arriving on NRET channels into one in-order stream.
// Defining RISCV_FORMAL_SEQ_TIMEOUT_EN adds a head-stall detector driving err_timeout.
module rvfi_order_sequencer #(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET*32-1:0]      rvfi_insn,
  input  logic [NRET-1:0]         rvfi_trap,
  input  logic [NRET*5-1:0]       rvfi_rs1_addr,
  input  logic [NRET*5-1:0]       rvfi_rs2_addr,
  input  logic [NRET*5-1:0]       rvfi_rd,
  input  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_rs2_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_post_rd,
  output logic                    out_valid,
  output logic [ORDER_W-1:0]      out_order,
  output logic [31:0]             out_insn,
  output logic                    out_trap,
  output logic [4:0]              out_rs1_addr,
  output logic [4:0]              out_rs2_addr,
  output logic [4:0]              out_rd,
  output logic [XLEN-1:0]         out_rs1_rdata,
  output logic [XLEN-1:0]         out_rs2_rdata,
  output logic [XLEN-1:0]         out_post_rd,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    err_window,
  output logic                    err_dup,
  output logic                    err_timeout
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [ORDER_W-1:0] WIN_SIZE = ORDER_W'(DEPTH);

  typedef struct packed {
    logic [31:0]     insn;
    logic            trap;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] post_rd;
  } entry_t;

  entry_t             slot_data [DEPTH];
  logic [DEPTH-1:0]   slot_valid;
  logic [DEPTH-1:0]   slot_valid_next;
  logic [ORDER_W-1:0] expected;
  entry_t             out_data;
  logic [IDX_W-1:0]   head_idx;
  logic               emit;
  logic [OCC_W-1:0]   occ_next;

  entry_t             in_entry [NRET];
  logic [ORDER_W-1:0] ch_order [NRET];
  logic [IDX_W-1:0]   ch_slot  [NRET];
  logic [NRET-1:0]    in_window;
  logic [NRET-1:0]    same_lower;
  logic [NRET-1:0]    wr_en;
  logic [NRET-1:0]    hit_window_err;
  logic [NRET-1:0]    hit_dup_err;

  // Only entries present before this edge may leave; a same-cycle head write waits a cycle.
  assign head_idx = expected[IDX_W-1:0];
  assign emit     = slot_valid[head_idx];

  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      ch_order[c]           = rvfi_order[c*ORDER_W +: ORDER_W];
      ch_slot[c]            = ch_order[c][IDX_W-1:0];
      in_entry[c].insn      = rvfi_insn[c*32 +: 32];
      in_entry[c].trap      = rvfi_trap[c];
      in_entry[c].rs1_addr  = rvfi_rs1_addr[c*5 +: 5];
      in_entry[c].rs2_addr  = rvfi_rs2_addr[c*5 +: 5];
      in_entry[c].rd        = rvfi_rd[c*5 +: 5];
      in_entry[c].rs1_rdata = rvfi_rs1_rdata[c*XLEN +: XLEN];
      in_entry[c].rs2_rdata = rvfi_rs2_rdata[c*XLEN +: XLEN];
      in_entry[c].post_rd   = rvfi_post_rd[c*XLEN +: XLEN];
    end
  end

  // Modulo distance from the head decides window membership; the lowest channel wins a tie.
  always_comb begin
    in_window      = '0;
    same_lower     = '0;
    wr_en          = '0;
    hit_window_err = '0;
    hit_dup_err    = '0;
    for (int c = 0; c < NRET; c++) begin
      in_window[c] = (ch_order[c] - expected) < WIN_SIZE;
      for (int k = 0; k < c; k++) begin
        if (rvfi_valid[k] && (ch_order[k] == ch_order[c])) begin
          same_lower[c] = 1'b1;
        end
      end
      hit_window_err[c] = rvfi_valid[c] && !in_window[c];
      hit_dup_err[c]    = rvfi_valid[c] &&
                          (same_lower[c] || (in_window[c] && slot_valid[ch_slot[c]]));
      wr_en[c]          = rvfi_valid[c] && in_window[c] && !same_lower[c] &&
                          !slot_valid[ch_slot[c]];
    end
  end

  always_comb begin
    slot_valid_next = slot_valid;
    occ_next        = occupancy;
    if (emit) begin
      slot_valid_next[head_idx] = 1'b0;
      occ_next                  = occ_next - OCC_W'(1);
    end
    for (int c = 0; c < NRET; c++) begin
      if (wr_en[c]) begin
        slot_valid_next[ch_slot[c]] = 1'b1;
        occ_next                    = occ_next + OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      expected   <= '0;
      slot_valid <= '0;
      occupancy  <= '0;
      out_valid  <= 1'b0;
      out_order  <= '0;
      out_data   <= '0;
      err_window <= 1'b0;
      err_dup    <= 1'b0;
    end else begin
      slot_valid <= slot_valid_next;
      occupancy  <= occ_next;
      out_valid  <= emit;
      if (emit) begin
        out_order <= expected;
        out_data  <= slot_data[head_idx];
        expected  <= expected + ORDER_W'(1);
      end
      if (|hit_window_err) err_window <= 1'b1;
      if (|hit_dup_err)    err_dup    <= 1'b1;
    end
  end

  // Payload storage is qualified by slot_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NRET; c++) begin
      if (wr_en[c]) begin
        slot_data[ch_slot[c]] <= in_entry[c];
      end
    end
  end

  assign out_insn      = out_data.insn;
  assign out_trap      = out_data.trap;
  assign out_rs1_addr  = out_data.rs1_addr;
  assign out_rs2_addr  = out_data.rs2_addr;
  assign out_rd        = out_data.rd;
  assign out_rs1_rdata = out_data.rs1_rdata;
  assign out_rs2_rdata = out_data.rs2_rdata;
  assign out_post_rd   = out_data.post_rd;

`ifdef RISCV_FORMAL_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_next;
  logic             err_timeout_q;

  // Counts cycles where entries are buffered but the head is missing; saturates at TIMEOUT.
  always_comb begin
    stall_cnt_next = stall_cnt;
    if (emit || (occupancy == '0)) begin
      stall_cnt_next = '0;
    end else if (stall_cnt != TIMEOUT_CNT) begin
      stall_cnt_next = stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      if (stall_cnt_next == TIMEOUT_CNT) err_timeout_q <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  // Detector absent: the flag is constant 0 for any legal (positive) TIMEOUT.
  assign err_timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_rvfi_order_sequencer.sv
// Scoreboard bench for rvfi_order_sequencer: an order-indexed reference model predicts emits.
// Honours RISCV_FORMAL_SEQ_TIMEOUT_EN for the head-stall checks.
module tb_rvfi_order_sequencer;

  localparam int NRET    = 2;
  localparam int XLEN    = 32;
  localparam int ORDER_W = 8;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 4;

  logic                    clk;
  logic                    resetn;
  logic [NRET-1:0]         rvfi_valid;
  logic [NRET*ORDER_W-1:0] rvfi_order;
  logic [NRET*32-1:0]      rvfi_insn;
  logic [NRET-1:0]         rvfi_trap;
  logic [NRET*5-1:0]       rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd;
  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_post_rd;
  logic                    out_valid;
  logic [ORDER_W-1:0]      out_order;
  logic [31:0]             out_insn;
  logic                    out_trap;
  logic [4:0]              out_rs1_addr, out_rs2_addr, out_rd;
  logic [XLEN-1:0]         out_rs1_rdata, out_rs2_rdata, out_post_rd;
  logic [$clog2(DEPTH):0]  occupancy;
  logic                    err_window, err_dup, err_timeout;

  rvfi_order_sequencer #(
    .NRET(NRET), .XLEN(XLEN), .ORDER_W(ORDER_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rd(rvfi_rd), .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_post_rd(rvfi_post_rd),
    .out_valid(out_valid), .out_order(out_order), .out_insn(out_insn), .out_trap(out_trap),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd(out_rd),
    .out_rs1_rdata(out_rs1_rdata), .out_rs2_rdata(out_rs2_rdata), .out_post_rd(out_post_rd),
    .occupancy(occupancy), .err_window(err_window), .err_dup(err_dup),
    .err_timeout(err_timeout)
  );

  typedef struct {
    int          order;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [31:0] rs1_rdata, rs2_rdata, post_rd;
  } retire_t;

  retire_t refData [256];
  bit      refPresent [256];
  int      refExpected;
  int      refCount;
  bit      refErrWindow;
  bit      refErrDup;
  retire_t expQ [$];

  int assertCount = 0;
  int failCount   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) refPresent[i] = 1'b0;
    refExpected  = 0;
    refCount     = 0;
    refErrWindow = 1'b0;
    refErrDup    = 1'b0;
    expQ.delete();
  endtask

  // One clock edge of the reference: the head leaves only if it was buffered before this edge.
  task automatic modelStep();
    bit      headReady;
    bit      dupLower;
    int      ord;
    retire_t r;
    headReady = refPresent[refExpected];
    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c]) begin
        ord = int'(rvfi_order[c*8 +: 8]);
        dupLower = 1'b0;
        for (int k = 0; k < c; k++)
          if (rvfi_valid[k] && int'(rvfi_order[k*8 +: 8]) == ord) dupLower = 1'b1;
        if (((ord - refExpected) & 255) >= DEPTH) refErrWindow = 1'b1;
        if (dupLower) begin
          refErrDup = 1'b1;
        end else if (((ord - refExpected) & 255) < DEPTH) begin
          if (refPresent[ord]) begin
            refErrDup = 1'b1;
          end else begin
            r.order     = ord;
            r.insn      = rvfi_insn[c*32 +: 32];
            r.trap      = rvfi_trap[c];
            r.rs1_addr  = rvfi_rs1_addr[c*5 +: 5];
            r.rs2_addr  = rvfi_rs2_addr[c*5 +: 5];
            r.rd        = rvfi_rd[c*5 +: 5];
            r.rs1_rdata = rvfi_rs1_rdata[c*XLEN +: XLEN];
            r.rs2_rdata = rvfi_rs2_rdata[c*XLEN +: XLEN];
            r.post_rd   = rvfi_post_rd[c*XLEN +: XLEN];
            refData[ord]    = r;
            refPresent[ord] = 1'b1;
            refCount++;
          end
        end
      end
    end
    if (headReady) begin
      expQ.push_back(refData[refExpected]);
      refPresent[refExpected] = 1'b0;
      refCount--;
      refExpected = (refExpected + 1) % 256;
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) modelReset();
    else         modelStep();
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    retire_t e;
    if (resetn) begin
      checkOutput("out_valid", out_valid, expQ.size() != 0);
      if (out_valid && expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("out_order", out_order, e.order);
        checkOutput("out_insn", out_insn, e.insn);
        checkOutput("out_fields", {out_trap, out_rs1_addr, out_rs2_addr, out_rd},
                    {e.trap, e.rs1_addr, e.rs2_addr, e.rd});
        checkOutput("out_rs1_rdata", out_rs1_rdata, e.rs1_rdata);
        checkOutput("out_rs2_rdata", out_rs2_rdata, e.rs2_rdata);
        checkOutput("out_post_rd", out_post_rd, e.post_rd);
      end
      checkOutput("occupancy", occupancy, refCount);
      checkOutput("err_window", err_window, refErrWindow);
      checkOutput("err_dup", err_dup, refErrDup);
`ifndef RISCV_FORMAL_SEQ_TIMEOUT_EN
      checkOutput("err_timeout_off", err_timeout, 0);
`endif
    end
  end

  task automatic applyStimulus(input bit [1:0] valid, input int o0, input int o1);
    rvfi_valid = valid;
    rvfi_order = {8'(o1), 8'(o0)};
    for (int c = 0; c < NRET; c++) begin
      rvfi_insn[c*32 +: 32]        = $urandom;
      rvfi_trap[c]                 = 1'($urandom_range(0, 1));
      rvfi_rs1_addr[c*5 +: 5]      = 5'($urandom);
      rvfi_rs2_addr[c*5 +: 5]      = 5'($urandom);
      rvfi_rd[c*5 +: 5]            = 5'($urandom);
      rvfi_rs1_rdata[c*XLEN +: XLEN] = $urandom;
      rvfi_rs2_rdata[c*XLEN +: XLEN] = $urandom;
      rvfi_post_rd[c*XLEN +: XLEN]   = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    rvfi_valid = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    int n;
    resetn = 1'b1;
    rvfi_valid = '0;
    rvfi_order = '0;
    rvfi_insn = '0;
    rvfi_trap = '0;
    rvfi_rs1_addr = '0;
    rvfi_rs2_addr = '0;
    rvfi_rd = '0;
    rvfi_rs1_rdata = '0;
    rvfi_rs2_rdata = '0;
    rvfi_post_rd = '0;
    #1 resetn = 1'b0;
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_out_order", out_order, 0);
    checkOutput("reset_out_insn", out_insn, 0);
    checkOutput("reset_errors", {err_window, err_dup, err_timeout}, 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] in-order single channel");
    applyStimulus(2'b01, 0, 0);
    applyStimulus(2'b01, 1, 0);
    applyStimulus(2'b01, 2, 0);
    idleCycles(4);
    checkOutput("inorder_no_errors", {err_window, err_dup}, 0);

    $display("[TB] out-of-order two channels");
    b = refExpected;
    applyStimulus(2'b11, b + 1, b);
    applyStimulus(2'b01, b + 3, 0);
    applyStimulus(2'b01, b + 2, 0);
    idleCycles(5);

    $display("[TB] wrap-around 255 -> 0");
    n = refExpected;
    while (n < 262) begin
      applyStimulus(2'b01, n, 0);
      n++;
    end
    idleCycles(4);
    checkOutput("wrap_last_order", out_order, 5);
    checkOutput("wrap_no_window_err", err_window, 0);

    $display("[TB] window violation");
    b = refExpected;
    applyStimulus(2'b01, b + DEPTH, 0);
    checkOutput("window_violation_flag", err_window, 1);
    checkOutput("window_violation_occ", occupancy, 0);

    $display("[TB] duplicate order on both channels");
    applyStimulus(2'b11, b + 3, b + 3);
    applyStimulus(2'b11, b, b + 1);
    applyStimulus(2'b01, b + 2, 0);
    idleCycles(6);
    checkOutput("dup_flag", err_dup, 1);

    $display("[TB] reset mid-operation");
    b = refExpected;
    applyStimulus(2'b11, b + 1, b + 2);
    idleCycles(1);
    checkOutput("occ_before_reset", occupancy, 2);
    #2 resetn = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_occupancy", occupancy, 0);
    checkOutput("midreset_errors", {err_window, err_dup}, 0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(2'b01, 0, 0);
    idleCycles(3);
    checkOutput("order0_after_reset", out_order, 0);

    $display("[TB] head stall");
    applyStimulus(2'b01, refExpected + 1, 0);
    idleCycles(TIMEOUT + 3);
`ifdef RISCV_FORMAL_SEQ_TIMEOUT_EN
    checkOutput("timeout_flag", err_timeout, 1);
`else
    checkOutput("timeout_flag", err_timeout, 0);
`endif
    applyStimulus(2'b01, refExpected, 0);
    idleCycles(4);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)),
                    refExpected + int'($urandom_range(0, DEPTH + 1)),
                    refExpected + int'($urandom_range(0, DEPTH + 1)));
    end
    for (int i = 0; i < 60 && refCount > 0; i++) begin
      applyStimulus(2'b01, refExpected, 0);
    end
    idleCycles(4);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    checkOutput("drained_occupancy", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
